// File: rtl/act_pwl_stream_if.sv
// Sample stream bundle for act_pwl_stream (input side and output side handshakes).
// in_mode is present only when ACT_PWL_TANH_MODE_EN is defined.
interface act_pwl_stream_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
`ifdef ACT_PWL_TANH_MODE_EN
  logic              in_mode;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

`ifdef ACT_PWL_TANH_MODE_EN
  modport master (output in_valid, in_data, in_mode, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_mode, out_ready,
                  output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/act_pwl_stream.sv
// Streaming 3-stage piecewise-linear activation with a programmable slope/bias table.
// Optional tanh mode (2*sigmoid(2x)-1) is enabled by defining ACT_PWL_TANH_MODE_EN.
module act_pwl_stream #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 9,
  parameter int RANGE_BITS = 3,
  parameter int SEG_BITS   = 6,
  parameter int COEF_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  act_pwl_stream_if.slave          s,
  input  logic                     cfg_we,
  input  logic [SEG_BITS-1:0]      cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_slope,
  input  logic signed [COEF_W-1:0] cfg_bias,
  input  logic                     clr_cnt,
  output logic [15:0]              clamp_cnt
);
  localparam int XW     = RANGE_BITS + FRAC_W + 1;
  localparam int DX_W   = XW - SEG_BITS;
  localparam int NSEG   = 1 << SEG_BITS;
  localparam int PROD_W = COEF_W + DX_W + 1;
  localparam int SUM_W  = COEF_W + 2;
  localparam int RES_W  = SUM_W + 2;
  localparam logic signed [DATA_W-1:0] X_MAX = DATA_W'((1 << (XW - 1)) - 1);
  localparam logic signed [DATA_W-1:0] X_MIN = DATA_W'(-(1 << (XW - 1)));
  localparam logic signed [RES_W-1:0]  Y_MAX = RES_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [RES_W-1:0]  Y_MIN = RES_W'(-(1 << (DATA_W - 1)));

  logic signed [COEF_W-1:0] slope_q [NSEG];
  logic signed [COEF_W-1:0] slope_d [NSEG];
  logic signed [COEF_W-1:0] bias_q  [NSEG];
  logic signed [COEF_W-1:0] bias_d  [NSEG];

  logic                     v1_q, v1_d, clp1_q, clp1_d;
  logic [SEG_BITS-1:0]      idx1_q, idx1_d;
  logic [DX_W-1:0]          dx1_q, dx1_d;
  logic                     v2_q, v2_d;
  logic signed [COEF_W-1:0] slope2_q, slope2_d, bias2_q, bias2_d;
  logic [DX_W-1:0]          dx2_q, dx2_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [15:0]              clamp_cnt_q, clamp_cnt_d;
`ifdef ACT_PWL_TANH_MODE_EN
  logic                     mode1_q, mode1_d, mode2_q, mode2_d;
`endif

  logic                     en;
  logic signed [DATA_W-1:0] x_src, xc;
  logic                     x_clamped;
  logic [XW-1:0]            xo;
  logic signed [PROD_W-1:0] prod, prod_sh;
  logic signed [SUM_W-1:0]  y_sum;
  logic signed [RES_W-1:0]  res;
  logic [DATA_W-1:0]        y_sat;

  // The whole pipeline moves as one; a held output freezes every stage.
  assign en         = !out_valid_q || s.out_ready;
  assign s.in_ready = en;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign clamp_cnt   = clamp_cnt_q;

  always_comb begin
    x_src     = s.in_data;
    x_clamped = 1'b0;
`ifdef ACT_PWL_TANH_MODE_EN
    if (s.in_mode) begin
      if (s.in_data[DATA_W-1] != s.in_data[DATA_W-2]) begin
        x_clamped = 1'b1;
        x_src = s.in_data[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        x_src = {s.in_data[DATA_W-2:0], 1'b0};
      end
    end
`endif
    xc = x_src;
    if (x_src > X_MAX) begin
      xc        = X_MAX;
      x_clamped = 1'b1;
    end else if (x_src < X_MIN) begin
      xc        = X_MIN;
      x_clamped = 1'b1;
    end
    // Adding 2^(XW-1) to an XW-bit two's complement value just flips its sign bit.
    xo = {~xc[XW-1], xc[XW-2:0]};
  end

  always_comb begin
    prod    = PROD_W'(slope2_q) * PROD_W'($signed({1'b0, dx2_q}));
    prod_sh = prod >>> FRAC_W;
    y_sum   = SUM_W'(bias2_q) + SUM_W'(prod_sh);
    res     = RES_W'(y_sum);
`ifdef ACT_PWL_TANH_MODE_EN
    if (mode2_q) begin
      res = (RES_W'(y_sum) <<< 1) - RES_W'(1 << FRAC_W);
    end
`endif
    y_sat = res[DATA_W-1:0];
    if (res > Y_MAX) begin
      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (res < Y_MIN) begin
      y_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  always_comb begin
    slope_d     = slope_q;
    bias_d      = bias_q;
    v1_d        = v1_q;
    clp1_d      = clp1_q;
    idx1_d      = idx1_q;
    dx1_d       = dx1_q;
    v2_d        = v2_q;
    slope2_d    = slope2_q;
    bias2_d     = bias2_q;
    dx2_d       = dx2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    clamp_cnt_d = clamp_cnt_q;
`ifdef ACT_PWL_TANH_MODE_EN
    mode1_d     = mode1_q;
    mode2_d     = mode2_q;
`endif
    if (cfg_we) begin
      slope_d[cfg_addr] = cfg_slope;
      bias_d[cfg_addr]  = cfg_bias;
    end
    if (en) begin
      v1_d        = s.in_valid;
      clp1_d      = x_clamped;
      idx1_d      = xo[XW-1 -: SEG_BITS];
      dx1_d       = xo[DX_W-1:0];
      v2_d        = v1_q;
      slope2_d    = slope_q[idx1_q];
      bias2_d     = bias_q[idx1_q];
      dx2_d       = dx1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_data_d = y_sat;
      end
`ifdef ACT_PWL_TANH_MODE_EN
      mode1_d     = s.in_mode;
      mode2_d     = mode1_q;
`endif
    end
    if (clr_cnt) begin
      clamp_cnt_d = '0;
    end else if (en && v1_q && clp1_q && clamp_cnt_q != 16'hFFFF) begin
      clamp_cnt_d = clamp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slope_q     <= '{default: '0};
      bias_q      <= '{default: '0};
      v1_q        <= 1'b0;
      clp1_q      <= 1'b0;
      idx1_q      <= '0;
      dx1_q       <= '0;
      v2_q        <= 1'b0;
      slope2_q    <= '0;
      bias2_q     <= '0;
      dx2_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clamp_cnt_q <= '0;
`ifdef ACT_PWL_TANH_MODE_EN
      mode1_q     <= 1'b0;
      mode2_q     <= 1'b0;
`endif
    end else begin
      slope_q     <= slope_d;
      bias_q      <= bias_d;
      v1_q        <= v1_d;
      clp1_q      <= clp1_d;
      idx1_q      <= idx1_d;
      dx1_q       <= dx1_d;
      v2_q        <= v2_d;
      slope2_q    <= slope2_d;
      bias2_q     <= bias2_d;
      dx2_q       <= dx2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      clamp_cnt_q <= clamp_cnt_d;
`ifdef ACT_PWL_TANH_MODE_EN
      mode1_q     <= mode1_d;
      mode2_q     <= mode2_d;
`endif
    end
  end
endmodule

// File: tb/tb_act_pwl_stream.sv
// Scoreboard bench for act_pwl_stream: stimulus pushes reference results, a monitor pops on each output transfer.
module tb_act_pwl_stream;
  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 9;
  localparam int RANGE_BITS = 3;
  localparam int SEG_BITS   = 6;
  localparam int COEF_W     = 16;
  localparam int XLIM       = 1 << (RANGE_BITS + FRAC_W);
  localparam int NSEG       = 1 << SEG_BITS;
  localparam int SEG_SPAN   = (2 * XLIM) / NSEG;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [SEG_BITS-1:0] cfg_addr;
  logic [COEF_W-1:0]   cfg_slope;
  logic [COEF_W-1:0]   cfg_bias;
  logic                clr_cnt;
  logic [15:0]         clamp_cnt;

  act_pwl_stream_if #(.DATA_W(DATA_W)) sif ();

  act_pwl_stream #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .RANGE_BITS(RANGE_BITS),
    .SEG_BITS(SEG_BITS), .COEF_W(COEF_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sif),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_slope (cfg_slope),
    .cfg_bias  (cfg_bias),
    .clr_cnt   (clr_cnt),
    .clamp_cnt (clamp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    int          acc_cyc;
    bit          lat_chk;
    int          x;
  } exp_t;

  exp_t q[$];
  int   m_slope[NSEG];
  int   m_bias[NSEG];
  int   exp_clamp;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   bp_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int floor_div(longint a, longint b);
    if (a >= 0) return int'(a / b);
    return int'(-((-a + b - 1) / b));
  endfunction

  // Reference: clamp to the table range, find segment and offset, evaluate line, saturate.
  function automatic logic [15:0] ref_y(int x);
    int xc, u, seg, dx, y;
    xc  = (x < -XLIM) ? -XLIM : ((x > XLIM - 1) ? XLIM - 1 : x);
    u   = xc + XLIM;
    seg = u / SEG_SPAN;
    dx  = u % SEG_SPAN;
    y   = m_bias[seg] + floor_div(longint'(m_slope[seg]) * dx, longint'(1 << FRAC_W));
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSEG; i++) begin
      m_slope[i] = 0;
      m_bias[i]  = 0;
    end
    exp_clamp = 0;
  endtask

  task automatic cfg_write(int addr, int slope, int bias);
    cfg_we    = 1'b1;
    cfg_addr  = SEG_BITS'(addr);
    cfg_slope = COEF_W'(slope);
    cfg_bias  = COEF_W'(bias);
    m_slope[addr] = int'($signed(16'(slope)));
    m_bias[addr]  = int'($signed(16'(bias)));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(int x, bit lat = 1'b0);
    int w;
    w = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = 16'(x);
    forever begin
      @(negedge clk);
      if (sif.in_ready) break;
      w++;
      if (w > 100) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    if (sif.in_ready) begin
      q.push_back('{ref_y(x), cyc, lat, x});
      if ((x < -XLIM || x > XLIM - 1) && exp_clamp < 16'hFFFF) exp_clamp++;
    end
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !sif.out_valid) break;
    end
    check("drain_pending", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Sole driver of out_ready; updates shortly after each rising edge.
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'b0;
        default: sif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each output transfer with the scoreboard and checks stall behaviour.
  initial begin
    logic        held;
    logic [15:0] held_data;
    exp_t        e;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_valid", int'(sif.out_valid), 1);
        check("hold_data", int'(sif.out_data), int'(held_data));
      end
      if (sif.out_valid && !sif.out_ready) begin
        check("stall_in_ready", int'(sif.in_ready), 0);
        held      = 1'b1;
        held_data = sif.out_data;
      end else begin
        held = 1'b0;
      end
      if (sif.out_valid && sif.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", int'(sif.out_valid), 0);
        end else begin
          e = q.pop_front();
          $display("out x=%0d y=0x%04h exp=0x%04h cyc=%0d", e.x, sif.out_data, e.y, cyc);
          check("out_data", int'(sif.out_data), int'(e.y));
          if (e.lat_chk) check("latency", cyc - e.acc_cyc, 3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int x;
    int seen;
    rst          = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
`ifdef ACT_PWL_TANH_MODE_EN
    sif.in_mode  = 1'b0;
`endif
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_slope = '0;
    cfg_bias  = '0;
    clr_cnt   = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(sif.out_valid), 0);
    check("reset_out_data", int'(sif.out_data), 0);
    check("reset_clamp_cnt", int'(clamp_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency and basic evaluation
    cfg_write(32, 'h0080, 'h0100);
    send(0, 1'b1);
    send('h40, 1'b1);
    wait_idle();

    // Clamp at both ends plus counter clear
    cfg_write(63, 0, 'h01FF);
    cfg_write(0, 0, 0);
    send('h7FFF);
    send(-32768);
    send(-XLIM);
    send(XLIM);
    wait_idle();
    check("clamp_cnt", int'(clamp_cnt), exp_clamp);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt   = 1'b0;
    exp_clamp = 0;
    check("clamp_cnt_clr", int'(clamp_cnt), 0);

    // Backpressure: six back-to-back samples against a stalled sink
    fork
      begin
        bp_mode = 1;
        repeat (6) @(posedge clk);
        #1;
        bp_mode = 0;
      end
      for (int i = 0; i < 6; i++) send(i * 200 - 500);
    join
    wait_idle();

    // Table write landing on the same edge as the lookup of an in-flight sample
    send(0);
    cfg_write(32, 'h0080, 'h0200);
    send(0);
    wait_idle();

    // Random table and samples with random backpressure
    for (int i = 0; i < NSEG; i++) cfg_write(i, int'($urandom), int'($urandom));
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 7))
        0, 1:    x = int'($signed(16'($urandom)));
        2:       x = -XLIM;
        3:       x = XLIM - 1 + int'($urandom_range(0, 1));
        default: x = int'($urandom_range(0, 2 * XLIM - 1)) - XLIM;
      endcase
      send(x);
    end
    bp_mode = 0;
    wait_idle();
    check("clamp_cnt_random", int'(clamp_cnt), exp_clamp);

    // Reset with three samples in flight
    bp_mode = 1;
    @(posedge clk);
    #1;
    send(100);
    send(-100);
    send(200);
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_out_valid_async", int'(sif.out_valid), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    bp_mode = 0;
    seen    = 0;
    repeat (10) begin
      @(negedge clk);
      if (sif.out_valid) seen++;
    end
    check("post_reset_outputs", seen, 0);
    check("post_reset_clamp_cnt", int'(clamp_cnt), 0);
    @(posedge clk);
    #1;
    send(0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
